// File: rtl/shared_mem_arbiter_pkg.sv
// Shared types for the processor shared-memory arbiter slice.
//   USIZE      : bits per memory element
//   BUS_W      : width of one bus beat
//   ADDR_W     : element address width (addr_t); wide enough to express
//                addresses past the end of the bank
//   arb_state_t: arbiter FSM states
//   mem_op_t   : operation latched for the granted requester
package shared_mem_arbiter_pkg;

  localparam int USIZE  = 8;
  localparam int BUS_W  = 32;
  localparam int ADDR_W = 16;

  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic {ARB, GRANT} arb_state_t;
  typedef enum logic {OP_RD, OP_WR} mem_op_t;

endpackage

// File: rtl/shared_mem_arbiter_if.sv
// Request/grant bus between the processor array and the shared-memory
// arbiter. Signal names are seen from the arbiter (responder) side.
//   i_req_rd/i_req_wr : per-proc level requests, held until granted
//   i_addr            : per-proc element address
//   i_wdata/i_wr_size : per-proc write beat and element count
//   i_wr_en           : per-proc write strobe, driven from its own grant
//   o_grant_rd/wr     : one-hot single-cycle grants
//   o_rdata           : shared read bus
//   o_busy            : arbiter is in its grant cycle
interface shared_mem_if
  import shared_mem_arbiter_pkg::*;
#(
  parameter int N_PROC = 4
) ();

  logic [N_PROC-1:0]            i_req_rd;
  logic [N_PROC-1:0]            i_req_wr;
  addr_t [N_PROC-1:0]           i_addr;
  logic [N_PROC-1:0][BUS_W-1:0] i_wdata;
  logic [N_PROC-1:0][2:0]       i_wr_size;
  logic [N_PROC-1:0]            i_wr_en;
  logic [N_PROC-1:0]            o_grant_rd;
  logic [N_PROC-1:0]            o_grant_wr;
  logic [BUS_W-1:0]             o_rdata;
  logic                         o_busy;

  modport slave (
    input  i_req_rd, i_req_wr, i_addr, i_wdata, i_wr_size, i_wr_en,
    output o_grant_rd, o_grant_wr, o_rdata, o_busy
  );

  modport master (
    output i_req_rd, i_req_wr, i_addr, i_wdata, i_wr_size, i_wr_en,
    input  o_grant_rd, o_grant_wr, o_rdata, o_busy
  );

endinterface

// File: rtl/shared_mem_arbiter_bank.sv
// Element-organised memory bank behind the arbiter.
//   i_clk      : write clock
//   i_rd_addr  : first element of an asynchronous SIMD_WIDTH-element read
//   o_rd_data  : read beat, element k at bits k*USIZE; elements past DEPTH read 0
//   i_wr_en    : write strobe for this cycle
//   i_wr_addr  : first element of the write
//   i_wr_size  : number of elements to write (capped at SIMD_WIDTH)
//   i_wr_data  : write beat; elements past DEPTH are dropped
// Contents are deliberately not reset.
module shared_mem_bank
  import shared_mem_arbiter_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int SIMD_WIDTH = BUS_W / USIZE
) (
  input  logic                          i_clk,
  input  addr_t                         i_rd_addr,
  output logic [SIMD_WIDTH*USIZE-1:0]   o_rd_data,
  input  logic                          i_wr_en,
  input  addr_t                         i_wr_addr,
  input  logic [2:0]                    i_wr_size,
  input  logic [SIMD_WIDTH*USIZE-1:0]   i_wr_data
);

  localparam int IDX_W = $clog2(DEPTH);
  // One extra bit so addr+k never wraps back into range.
  localparam int EA_W  = ADDR_W + 1;

  logic [USIZE-1:0] mem_q [DEPTH];
  logic [EA_W-1:0]  rd_ea [SIMD_WIDTH];
  logic [EA_W-1:0]  wr_ea [SIMD_WIDTH];
  logic [SIMD_WIDTH-1:0] wr_lane;

  always_comb begin
    o_rd_data = '0;
    wr_lane   = '0;
    for (int k = 0; k < SIMD_WIDTH; k++) begin
      rd_ea[k] = {1'b0, i_rd_addr} + EA_W'(k);
      wr_ea[k] = {1'b0, i_wr_addr} + EA_W'(k);
      if (rd_ea[k] < EA_W'(DEPTH))
        o_rd_data[k*USIZE +: USIZE] = mem_q[rd_ea[k][IDX_W-1:0]];
      wr_lane[k] = i_wr_en && (k < int'(i_wr_size)) && (wr_ea[k] < EA_W'(DEPTH));
    end
  end

  always_ff @(posedge i_clk) begin
    for (int k = 0; k < SIMD_WIDTH; k++) begin
      if (wr_lane[k])
        mem_q[wr_ea[k][IDX_W-1:0]] <= i_wr_data[k*USIZE +: USIZE];
    end
  end

endmodule

// File: rtl/shared_mem_arbiter.sv
// Responder end of the shared-memory request/grant protocol.
// Round-robin arbitration over N_PROC requesters; each win produces one
// registered grant cycle in which the winner's read or write is served
// against the internal bank.
//   i_clk  : clock
//   i_rstn : asynchronous active-low reset
//   bus    : shared_mem_if slave side (requests, grants, read bus, busy)
module shared_mem_arbiter
  import shared_mem_arbiter_pkg::*;
#(
  parameter int N_PROC     = 4,
  parameter int SIMD_WIDTH = BUS_W / USIZE,
  parameter int DEPTH      = 256
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  shared_mem_if.slave   bus
);

  localparam int PTR_W = (N_PROC > 1) ? $clog2(N_PROC) : 1;

  arb_state_t        state_q;
  mem_op_t           op_q, op_d;
  logic [PTR_W-1:0]  rr_q, rr_d;
  logic [PTR_W-1:0]  winner_q, winner_d;
  logic [N_PROC-1:0] win_oh_d;
  logic [N_PROC-1:0] grant_rd_q, grant_wr_q;
  logic              busy_q;
  logic [N_PROC-1:0] req;
  logic              req_any;

  logic [BUS_W-1:0]  bank_rdata;
  logic              bank_wr_en;
  logic              rd_grant;

  // Cyclic first-set search starting at the rr pointer.
  always_comb begin
    int idx;
    logic found;
    idx      = 0;
    found    = 1'b0;
    req      = bus.i_req_rd | bus.i_req_wr;
    req_any  = |req;
    winner_d = rr_q;
    for (int off = 0; off < N_PROC; off++) begin
      idx = (int'(rr_q) + off) % N_PROC;
      if (!found && req[PTR_W'(idx)]) begin
        found    = 1'b1;
        winner_d = PTR_W'(idx);
      end
    end
    // A simultaneous rd+wr is served as a read; the write waits.
    op_d     = bus.i_req_rd[winner_d] ? OP_RD : OP_WR;
    win_oh_d = N_PROC'(1) << winner_d;
    rr_d     = (winner_q == PTR_W'(N_PROC - 1)) ? '0 : winner_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_q    <= ARB;
      op_q       <= OP_RD;
      rr_q       <= '0;
      winner_q   <= '0;
      grant_rd_q <= '0;
      grant_wr_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        ARB: begin
          if (req_any) begin
            winner_q   <= winner_d;
            op_q       <= op_d;
            grant_rd_q <= (op_d == OP_RD) ? win_oh_d : '0;
            grant_wr_q <= (op_d == OP_WR) ? win_oh_d : '0;
            busy_q     <= 1'b1;
            state_q    <= GRANT;
          end
        end
        GRANT: begin
          grant_rd_q <= '0;
          grant_wr_q <= '0;
          busy_q     <= 1'b0;
          rr_q       <= rr_d;
          state_q    <= ARB;
        end
        default: state_q <= ARB;
      endcase
    end
  end

  // The write commits on the edge closing the grant cycle; an async reset
  // before that edge returns state_q to ARB and so cancels it.
  assign rd_grant   = (state_q == GRANT) && (op_q == OP_RD);
  assign bank_wr_en = (state_q == GRANT) && (op_q == OP_WR) && bus.i_wr_en[winner_q];

  shared_mem_bank #(
    .DEPTH      (DEPTH),
    .SIMD_WIDTH (SIMD_WIDTH)
  ) u_bank (
    .i_clk     (i_clk),
    .i_rd_addr (bus.i_addr[winner_q]),
    .o_rd_data (bank_rdata),
    .i_wr_en   (bank_wr_en),
    .i_wr_addr (bus.i_addr[winner_q]),
    .i_wr_size (bus.i_wr_size[winner_q]),
    .i_wr_data (bus.i_wdata[winner_q])
  );

  assign bus.o_grant_rd = grant_rd_q;
  assign bus.o_grant_wr = grant_wr_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_rdata    = rd_grant ? bank_rdata : '0;

endmodule

// File: tb/tb_shared_mem_arbiter.sv
module tb_shared_mem_arbiter;
  import shared_mem_arbiter_pkg::*;

  localparam int NP    = 4;
  localparam int SW    = 4;
  localparam int DEPTH = 256;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  shared_mem_if #(.N_PROC(NP)) bus ();

  shared_mem_arbiter #(
    .N_PROC     (NP),
    .SIMD_WIDTH (SW),
    .DEPTH      (DEPTH)
  ) dut (
    .i_clk  (clk),
    .i_rstn (rstn),
    .bus    (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [7:0] m_mem [DEPTH];

  typedef struct {
    bit          is_wr;
    int          p;
    int          addr;
    int          size;
    logic [31:0] data;
    bit          we;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(bit w, int p, int a, int s, logic [31:0] d, bit we, logic [31:0] e);
    vec_t v;
    v.is_wr = w; v.p = p; v.addr = a; v.size = s; v.data = d; v.we = we; v.exp = e;
    return v;
  endfunction

  function automatic logic [31:0] model_rd(int addr);
    logic [31:0] r;
    r = '0;
    for (int k = 0; k < SW; k++)
      if (addr + k < DEPTH) r[k*8 +: 8] = m_mem[addr + k];
    return r;
  endfunction

  task automatic model_wr(input int addr, input int size, input logic [31:0] data);
    for (int k = 0; k < SW && k < size; k++)
      if (addr + k < DEPTH) m_mem[addr + k] = data[k*8 +: 8];
  endtask

  function automatic int oh_idx(logic [NP-1:0] v);
    int n, idx;
    n = 0; idx = -1;
    for (int i = 0; i < NP; i++) if (v[i]) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic clear_inputs();
    bus.i_req_rd = '0; bus.i_req_wr = '0; bus.i_wr_en = '0;
    bus.i_addr = '0; bus.i_wdata = '0; bus.i_wr_size = '0;
  endtask

  task automatic wait_grant(input int p, input bit wr, output int lat, output bit ok);
    ok = 1'b0; lat = 0;
    for (int i = 1; i <= 2*NP + 2 && !ok; i++) begin
      @(negedge clk);
      if (wr ? bus.o_grant_wr[p] : bus.o_grant_rd[p]) begin ok = 1'b1; lat = i; end
    end
  endtask

  // One transfer for one proc, started while the arbiter is idle.
  task automatic do_xfer(input string nm, input bit wr, input int p, input int addr,
                         input int size, input logic [31:0] data, input bit we,
                         input bit chk_rd, input logic [31:0] exp);
    int lat; bit ok;
    bus.i_addr[p] = addr_t'(addr);
    bus.i_wdata[p] = data;
    bus.i_wr_size[p] = 3'(size);
    if (wr) bus.i_req_wr[p] = 1'b1; else bus.i_req_rd[p] = 1'b1;
    wait_grant(p, wr, lat, ok);
    check({nm, "_granted"}, 32'(ok), 32'd1);
    if (ok) begin
      check({nm, "_latency"}, lat, 2);
      check({nm, "_gvec"}, 32'(wr ? bus.o_grant_wr : bus.o_grant_rd), 32'(1) << p);
      check({nm, "_other"}, 32'(wr ? bus.o_grant_rd : bus.o_grant_wr), 32'd0);
      check({nm, "_busy"}, 32'(bus.o_busy), 32'd1);
      if (wr) begin
        check({nm, "_rdata0"}, bus.o_rdata, 32'd0);
        bus.i_wr_en[p] = we;
      end else if (chk_rd) begin
        check({nm, "_rdata"}, bus.o_rdata, exp);
      end
    end
    @(posedge clk); #1;
    bus.i_req_rd[p] = 1'b0; bus.i_req_wr[p] = 1'b0; bus.i_wr_en[p] = 1'b0;
    if (ok && wr && we) model_wr(addr, size, data);
  endtask

  task automatic rr_run(input logic [NP-1:0] reqs, input int n,
                        output int ord [NP], output int ts [NP], output int got);
    int g;
    got = 0;
    for (int i = 0; i < NP; i++) begin ord[i] = -1; ts[i] = -1; end
    bus.i_req_rd = reqs;
    for (int c = 1; c <= 4*NP && got < n; c++) begin
      @(negedge clk);
      g = oh_idx(bus.o_grant_rd);
      if (g >= 0 && got < NP) begin
        ord[got] = g; ts[got] = c;
        check($sformatf("rr_rdata%0d", got), bus.o_rdata, model_rd(int'(bus.i_addr[g])));
        got++;
      end
      @(posedge clk); #1;
      if (g >= 0) bus.i_req_rd[g] = 1'b0;
    end
    bus.i_req_rd = '0;
  endtask

  task automatic random_phase(input int ncyc);
    int exp_g, rr, prev_g, pw_addr, pw_size, kind;
    bit exp_rd, prev_rd, pw;
    logic [31:0] pw_data;
    logic [NP-1:0] req;
    exp_g = -1; exp_rd = 1'b0; rr = 0; prev_g = -1; prev_rd = 1'b0; pw = 1'b0;
    pw_addr = 0; pw_size = 0; pw_data = '0;
    for (int c = 0; c < ncyc; c++) begin
      if (pw) model_wr(pw_addr, pw_size, pw_data);
      pw = 1'b0;
      if (prev_g >= 0) begin
        if (prev_rd) bus.i_req_rd[prev_g] = 1'b0; else bus.i_req_wr[prev_g] = 1'b0;
      end
      bus.i_wr_en = '0;
      for (int p = 0; p < NP; p++) begin
        if (!bus.i_req_rd[p] && !bus.i_req_wr[p] && $urandom_range(0, 2) == 0) begin
          kind = $urandom_range(0, 2);
          bus.i_addr[p] = addr_t'($urandom_range(0, DEPTH + 3));
          bus.i_wdata[p] = $urandom;
          bus.i_wr_size[p] = 3'($urandom_range(0, 7));
          bus.i_req_rd[p] = (kind != 1);
          bus.i_req_wr[p] = (kind != 0);
        end
      end
      @(negedge clk);
      check("rnd_busy", 32'(bus.o_busy), 32'(exp_g >= 0));
      check("rnd_grant_rd", 32'(bus.o_grant_rd), (exp_g >= 0 && exp_rd) ? 32'(1) << exp_g : 32'd0);
      check("rnd_grant_wr", 32'(bus.o_grant_wr), (exp_g >= 0 && !exp_rd) ? 32'(1) << exp_g : 32'd0);
      check("rnd_rdata", bus.o_rdata,
            (exp_g >= 0 && exp_rd) ? model_rd(int'(bus.i_addr[exp_g])) : 32'd0);
      if (exp_g >= 0 && !exp_rd) begin
        pw = 1'($urandom_range(0, 1));
        bus.i_wr_en[exp_g] = pw;
        pw_addr = int'(bus.i_addr[exp_g]);
        pw_size = int'(bus.i_wr_size[exp_g]);
        pw_data = bus.i_wdata[exp_g];
      end
      prev_g = exp_g; prev_rd = exp_rd;
      if (exp_g >= 0) begin
        rr = (exp_g + 1) % NP;
        exp_g = -1;
      end else begin
        req = bus.i_req_rd | bus.i_req_wr;
        for (int o = 0; o < NP; o++)
          if (exp_g < 0 && req[(rr + o) % NP]) exp_g = (rr + o) % NP;
        if (exp_g >= 0) exp_rd = bus.i_req_rd[exp_g];
      end
      @(posedge clk); #1;
    end
    if (pw) model_wr(pw_addr, pw_size, pw_data);
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ord [NP];
    int ts [NP];
    int got, lat;
    bit ok;

    tbl[0]  = mk(1, 0,   8, 4, 32'h04030201, 1, 32'h0);
    tbl[1]  = mk(0, 0,   8, 0, 32'h0,        0, 32'h04030201);
    tbl[2]  = mk(1, 2,   0, 4, 32'h09090909, 1, 32'h0);
    tbl[3]  = mk(1, 2,   0, 2, 32'h08070605, 1, 32'h0);
    tbl[4]  = mk(0, 3,   0, 0, 32'h0,        0, 32'h09090605);
    tbl[5]  = mk(1, 0,   0, 0, 32'h11111111, 1, 32'h0);
    tbl[6]  = mk(0, 0,   0, 0, 32'h0,        0, 32'h09090605);
    tbl[7]  = mk(1, 1, 254, 4, 32'h0d0c0b0a, 1, 32'h0);
    tbl[8]  = mk(0, 1, 254, 0, 32'h0,        0, 32'h00000b0a);
    tbl[9]  = mk(0, 2,   0, 0, 32'h0,        0, 32'h09090605);
    tbl[10] = mk(1, 1,   8, 4, 32'hffffffff, 0, 32'h0);
    tbl[11] = mk(0, 1,   8, 0, 32'h0,        0, 32'h04030201);
    tbl[12] = mk(1, 3,   4, 7, 32'h44332211, 1, 32'h0);
    tbl[13] = mk(0, 3,   4, 0, 32'h0,        0, 32'h44332211);
    tbl[14] = mk(0, 0, 255, 0, 32'h0,        0, 32'h0000000b);

    clear_inputs();
    rstn = 1'b0;
    @(posedge clk); #1;
    check("rst_grant_rd", 32'(bus.o_grant_rd), 32'd0);
    check("rst_grant_wr", 32'(bus.o_grant_wr), 32'd0);
    check("rst_rdata", bus.o_rdata, 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
    @(posedge clk); #2;
    rstn = 1'b1;
    @(posedge clk); #1;

    // Round robin: all four from the same cycle, addresses out of range.
    for (int p = 0; p < NP; p++) bus.i_addr[p] = addr_t'(DEPTH);
    rr_run(4'b1111, 4, ord, ts, got);
    check("rr4_count", got, 4);
    for (int i = 0; i < NP; i++) begin
      check($sformatf("rr4_order%0d", i), ord[i], i);
      check($sformatf("rr4_time%0d", i), ts[i], 2 + 2*i);
    end
    rr_run(4'b0101, 2, ord, ts, got);
    check("rr2_count", got, 2);
    check("rr2_first", ord[0], 0);
    check("rr2_second", ord[1], 2);

    foreach (tbl[i])
      do_xfer($sformatf("vec%0d", i), tbl[i].is_wr, tbl[i].p, tbl[i].addr, tbl[i].size,
              tbl[i].data, tbl[i].we, !tbl[i].is_wr, tbl[i].exp);

    // Reset in the middle of a write grant from proc1.
    bus.i_addr[1] = addr_t'(8);
    bus.i_wdata[1] = 32'hdeadbeef;
    bus.i_wr_size[1] = 3'd4;
    bus.i_req_wr[1] = 1'b1;
    wait_grant(1, 1'b1, lat, ok);
    check("rmg_granted", 32'(ok), 32'd1);
    bus.i_wr_en[1] = 1'b1;
    #1;
    rstn = 1'b0;
    #1;
    check("rmg_grant_wr", 32'(bus.o_grant_wr), 32'd0);
    check("rmg_grant_rd", 32'(bus.o_grant_rd), 32'd0);
    check("rmg_rdata", bus.o_rdata, 32'd0);
    check("rmg_busy", 32'(bus.o_busy), 32'd0);
    @(posedge clk); #1;
    clear_inputs();
    #3;
    rstn = 1'b1;
    for (int p = 0; p < NP; p++) bus.i_addr[p] = addr_t'(8);
    rr_run(4'b0101, 2, ord, ts, got);
    check("rmg_rr_first", ord[0], 0);
    check("rmg_rr_second", ord[1], 2);
    do_xfer("rmg_readback", 1'b0, 3, 8, 0, 32'h0, 1'b0, 1'b1, 32'h04030201);

    // Fill the whole bank so random reads never see uninitialised data.
    for (int a = 0; a < DEPTH; a += 4)
      do_xfer("preload", 1'b1, (a / 4) % NP, a, 4, $urandom, 1'b1, 1'b0, 32'h0);

    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    random_phase(600);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shared_mem_arbiter.md
Name: shared_mem_arbiter

Overview:
Responder end of the processor shared-memory read/write request/grant protocol. Arbitrates N_PROC requesters round-robin and issues single-cycle read or write grants. During the grant cycle it serves one BUS_W-wide, element-addressed transfer against an internal element-organised memory bank. Sits between the proc array and the shared data store; its read bus feeds every proc's i_data.

Parameters:
N_PROC, 4, number of requesting processors
SIMD_WIDTH, `BUS_W/`USIZE, elements per bus beat
DEPTH, 256, memory depth in `USIZE elements (power of two, <= addressable range of addr_t)

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset, asynchronous, active-low
i_req_rd  in  [N_PROC]  read request per proc, level, held until granted
i_req_wr  in  [N_PROC]  write request per proc, level, held until granted
i_addr  in  addr_t [N_PROC]  element address per proc
i_wdata  in  [N_PROC][`BUS_W]  write data per proc; element k at bits k*`USIZE +: `USIZE
i_wr_size  in  [N_PROC][3]  elements to write
i_wr_en  in  [N_PROC]  write strobe; proc drives it combinationally from its own grant
o_grant_rd  out  [N_PROC]  one-hot read grant, one-cycle pulse
o_grant_wr  out  [N_PROC]  one-hot write grant, one-cycle pulse
o_rdata  out  `BUS_W  shared read data bus
o_busy  out  1  high in GRANT state

Behaviour:
- Reset: state ARB, rr pointer 0, winner 0, all grants 0, o_rdata 0, o_busy 0. Memory contents are not reset.
- FSM has two states: ARB and GRANT.
- ARB:
  - Form req[i] = i_req_rd[i] | i_req_wr[i].
  - If any req is set: register as winner the first set index at or after rr pointer, searching cyclically. Register the op: rd if i_req_rd[winner], else wr. Go to GRANT.
  - Otherwise stay in ARB.
- GRANT:
  - Assert o_grant_rd[winner] or o_grant_wr[winner] for exactly one cycle. Grants are registered, so they are asserted for the whole cycle.
  - Set rr pointer to (winner+1) mod N_PROC. Return to ARB.
- Throughput and latency:
  - At most one transfer every 2 cycles.
  - Request at cycle t while ARB is idle -> grant at t+1.
  - Requester waits at most 2*N_PROC cycles.
- A requester asserting both rd and wr in the same cycle gets a read; the write stays pending for a later round.
- Read (GRANT, op rd):
  - o_rdata element k = mem[i_addr[winner]+k], for k in 0..SIMD_WIDTH-1.
  - Driven combinationally (async bank read) in the grant cycle, so the proc latches it in the same cycle.
  - Elements with address >= DEPTH read 0.
  - o_rdata is 0 outside read-grant cycles.
- Write (GRANT, op wr):
  - Takes effect at the clock edge ending the grant cycle, only if i_wr_en[winner]=1.
  - Writes elements k < min(i_wr_size[winner], SIMD_WIDTH): mem[addr+k] <= i_wdata[winner] element k.
  - Size 0 writes nothing. Elements with address >= DEPTH are dropped (no wrap).
  - No i_wr_en in the grant cycle means no write; the grant is still consumed.
- Requests that drop before being granted are simply not served; no error is raised.
- Reset mid-GRANT: grant deasserts immediately (asynchronous). Any write in flight is discarded.
- Only the winner's inputs are sampled. Other procs' addr/data are don't-care.

Decomposition:
- Shared package (defines.sv / existing types): addr_t, `BUS_W, `USIZE.
- Add to the package:
  - arb_state_t enum {ARB, GRANT}
  - mem_op_t {OP_RD, OP_WR}
- Sub-module shared_mem_bank(DEPTH, SIMD_WIDTH):
  - async multi-element read of SIMD_WIDTH consecutive elements, with out-of-range zeroing
  - sync masked write of 1..SIMD_WIDTH consecutive elements, with out-of-range drop
- The arbiter FSM, rr pointer and muxing stay in shared_mem_arbiter.

Test Plan:
- Single write then read: proc0 wr addr 8, size 4 (SIMD_WIDTH=4), data elements {1,2,3,4}; then proc0 rd addr 8 -> grant_wr[0] at t+1; later grant_rd[0] with o_rdata elements {1,2,3,4}.
- Partial write: preload addr 0..3 = {9,9,9,9}; wr addr 0 size 2 data {5,6,7,8}; rd addr 0 -> {5,6,9,9}. Size 0 write leaves {5,6,9,9}.
- Round-robin: all 4 procs hold req_rd from the same cycle -> grants in order 0,1,2,3, one every 2 cycles. Re-assert proc0 and proc2 after rr=0 -> 0 then 2.
- Boundary: wr addr DEPTH-2 size 4 data {a,b,c,d} -> mem[DEPTH-2]=a, mem[DEPTH-1]=b, mem[0] unchanged; rd addr DEPTH-2 -> {a,b,0,0}.
- Grant without wr_en: proc1 req_wr, keeps i_wr_en=0 in grant cycle -> memory unchanged, arbiter returns to ARB.
- Reset mid-GRANT: assert i_rstn=0 during a write grant -> grants 0 and o_rdata 0 immediately; target address keeps its old value; after release, rr pointer is 0.
